// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Ceiling log2, with clog2(1) == 0; bounded loop keeps it elaboration-safe.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after
// rr_ptr, wrapping at NUM_REQ (which need not be a power of two).
module rr_picker import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  // One extra bit so rr_ptr + offset never overflows before the wrap compare.
  logic [ID_W:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ))
        idx = idx - (ID_W + 1)'(NUM_REQ);
      if (req[idx[ID_W-1:0]]) begin
        any    = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX core among NUM_REQ byte producers.
// Accepts one byte, pulses tx_start, then follows tx_busy to frame end,
// dropping the byte if the core never reports busy within START_TO cycles.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ID_W     = clog2(NUM_REQ),
  parameter int START_TO = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      done,
  output logic                      timeout_err
);

  localparam int CNT_W = clog2(START_TO + 1);

  state_t                           state, state_nx;
  logic [ID_W-1:0]                  rr_ptr, winner, ptr_nx;
  logic                             any, accept;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_bytes;

  assign req_bytes = req_data;

  // Pointer moves one past the owner of the frame that just ended.
  assign ptr_nx = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .any    (any),
    .winner (winner)
  );

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and strobe decode. req_ready is masked while reset is held
  // so a producer never sees an accept that the FSM does not take.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    req_ready   = '0;
    tx_start    = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (reset && any && !tx_busy) begin
          accept    = 1'b1;
          req_ready = NUM_REQ'(1) << winner;
          state_nx  = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // busy arriving on the last allowed cycle still counts as a launch
        if (tx_busy) state_nx = WAIT_DONE;
        else if (cnt == CNT_W'(START_TO)) begin
          timeout_err = 1'b1;
          state_nx    = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Captured byte/owner, frame-active flag, round-robin pointer, start timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        tx_data  <= req_bytes[winner];
        grant_id <= winner;
        active   <= 1'b1;
      end else if (done || timeout_err) begin
        active <= 1'b0;
        rr_ptr <= ptr_nx;
      end
      if (state == LAUNCH)
        cnt <= '0;
      else if (state == WAIT_BUSY && !tx_busy && cnt != CNT_W'(START_TO))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single UART transmitter core among NUM_REQ independent byte producers using round-robin arbitration. It accepts one byte at a time over a valid/ready handshake and launches it with a one-cycle tx_start pulse. It then tracks the core's tx_busy until the frame completes. The block sits between the system-side producers and the UART TX core, all in the clk domain; the baud clock stays internal to the TX core.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, data bits per frame
ID_W, $clog2(NUM_REQ), width of requester index
START_TO, 15, max clk cycles from tx_start to tx_busy rising before timeout (≥1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept strobe (combinational)
tx_start  output  1  one-cycle launch pulse to TX core
tx_data  output  DATA_W  registered byte, stable from tx_start until frame done
tx_busy  input  1  TX core frame in progress (synchronous to clk)
grant_id  output  ID_W  index of requester owning the current frame
active  output  1  high from accept until frame done
done  output  1  one-cycle pulse when frame completes
timeout_err  output  1  one-cycle pulse when tx_busy never rose

Behaviour:
- Reset values: state IDLE, rr_ptr 0, tx_data 0, grant_id 0, tx_start/active/done/timeout_err 0, timeout counter 0.
- Reset mid-frame aborts immediately. No stale tx_start is issued after reset release.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE (2-bit encoding).
- IDLE: winner is the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap at NUM_REQ.
  - req_ready = one-hot(winner) only when state==IDLE and |req_valid. Otherwise req_ready = 0.
  - On the accept cycle: tx_data <= req_data[winner], grant_id <= winner, active <= 1, next state LAUNCH.
  - If tx_busy=1 while in IDLE (core still busy from another source), the arbiter does not accept; req_ready = 0.
- LAUNCH: tx_start=1 for exactly this cycle. Counter cleared. Next state WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else the counter increments. When the counter reaches START_TO: pulse timeout_err, clear active, advance rr_ptr to grant_id+1 (mod NUM_REQ), go to IDLE. The byte is dropped.
- WAIT_DONE: when tx_busy=0, pulse done, clear active, set rr_ptr <= grant_id+1 (wrap NUM_REQ-1 -> 0), go to IDLE.
- Latency: accept at cycle T, tx_start at T+1. Earliest next accept is the cycle after done.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Simultaneous events:
  - A requester dropping req_valid in the same cycle it wins still counts as accepted; valid and ready are evaluated in the same cycle.
  - tx_busy rising in the same cycle the counter hits START_TO counts as success. No timeout is flagged.
- tx_data and grant_id hold their values from accept until the next accept; they do not change on done.
- Index arithmetic uses ID_W bits with explicit wrap compare. NUM_REQ need not be a power of two.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE
  - default DATA_W = 8
  - function clog2
- Natural sub-module: rr_picker, a combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, winner index.
- The FSM, data register and timeout counter stay in uart_tx_arbiter.

Test Plan:
1. Reset with req_valid=4'b0010 held -> no req_ready, tx_start or done until reset release. After release: req_ready=4'b0010 on the first cycle, tx_start on the next, tx_data equals that byte.
2. Single request: req_valid[2]=1, req_data[2]=8'hA5, then model tx_busy high 3 cycles after tx_start for 10 cycles -> tx_data=A5, grant_id=2, done pulses once when tx_busy falls, rr_ptr=3.
3. All four valid continuously with bytes 10,11,12,13 -> grants in order 0,1,2,3,0. tx_data sequence 10,11,12,13,10. Exactly one tx_start per frame.
4. Requester 3 only, with rr_ptr=3 after the prior grant -> wraps: grant_id 3, then next rr_ptr=0. With NUM_REQ=3, verify wrap 2->0.
5. TX core never asserts tx_busy -> timeout_err pulses exactly START_TO cycles after WAIT_BUSY entry, active falls, no done, and the next requester is served.
6. Assert reset during WAIT_DONE -> all outputs return to reset values asynchronously. After release, the pending requester is re-arbitrated from index 0.
